// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-requester Avalon-MM arbiter in front of the 5120x32 on-chip RAM
// Grant is combinational from registered state; read data is steered to its owner one cycle later.
module onchip_mem_arbiter #(
  parameter int ADDR_W        = 13,
  parameter int DEPTH         = 5120,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clear
);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      STARVE_L = 8'(STARVE_LIMIT);

  logic              m0_req, m1_req, gnt0, gnt1, any_gnt, sel_wr, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_grant_q, last_grant_d;  // 1 = m1 owned the last grant
  logic [7:0]        starve_q, starve_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d, rzero_q, rzero_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (PRIORITY_MODE == 0) begin
          gnt0 = last_grant_q;
          gnt1 = ~last_grant_q;
        end else begin
          gnt1 = (starve_q == STARVE_L);
          gnt0 = ~gnt1;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign sel_addr = gnt1 ? m1_address : m0_address;
  assign sel_wr   = gnt1 ? m1_write   : m0_write;
  assign in_range = ({1'b0, sel_addr} < DEPTH_L);

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_address    = sel_addr;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = any_gnt & in_range;
  assign mem_write      = any_gnt & in_range & sel_wr;
  assign mem_clken      = 1'b1;

  // A port asserting read and write together is treated as a write only.
  always_comb begin
    last_grant_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_grant_q);
    starve_d     = starve_q;
    if (gnt1)
      starve_d = 8'd0;
    else if (m1_req && starve_q != 8'hFF)
      starve_d = starve_q + 8'd1;
    rvalid0_d  = gnt0 & m0_read & ~m0_write;
    rvalid1_d  = gnt1 & m1_read & ~m1_write;
    rzero_d    = ~in_range;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    if (any_gnt && !in_range && (!err_flag_q || err_clear)) begin
      err_flag_d = 1'b1;
      err_addr_d = sel_addr;
    end else if (err_clear) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      starve_q     <= 8'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rzero_q      <= 1'b0;
      err_flag_q   <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rzero_q      <= rzero_d;
      err_flag_q   <= err_flag_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Masking with reset kills a response whose acceptance is followed by reset.
  assign m0_readdatavalid = rvalid0_q & ~reset;
  assign m1_readdatavalid = rvalid1_q & ~reset;
  assign m0_readdata      = (m0_readdatavalid && !rzero_q) ? mem_readdata : 32'h0;
  assign m1_readdata      = (m1_readdatavalid && !rzero_q) ? mem_readdata : 32'h0;
  assign err_flag         = err_flag_q;
  assign err_addr         = err_addr_q;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench: round-robin instance plus a fixed-priority instance
// Expected read responses are queued at acceptance and popped by a monitor on readdatavalid.
module tb_onchip_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, err_clear;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [12:0] mem_address, err_addr;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, err_flag;
  logic [31:0] mem_writedata, mem_readdata;

  logic        s0_read, s1_read;
  logic        s_m0_waitrequest, s_m1_waitrequest, s_m0_readdatavalid, s_m1_readdatavalid;
  logic [31:0] s_m0_readdata, s_m1_readdata, s_mem_writedata;
  logic [12:0] s_mem_address, s_err_addr;
  logic [3:0]  s_mem_byteenable;
  logic        s_mem_chipselect, s_mem_write, s_mem_clken, s_err_flag;
  logic [31:0] s_mem_readdata = 32'hC0FFEE00;

  onchip_mem_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_flag(err_flag), .err_addr(err_addr), .err_clear(err_clear)
  );

  onchip_mem_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(3)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(s0_read), .m0_write(1'b0),
    .m0_writedata(m0_writedata), .m0_waitrequest(s_m0_waitrequest), .m0_readdata(s_m0_readdata),
    .m0_readdatavalid(s_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(s1_read), .m1_write(1'b0),
    .m1_writedata(m1_writedata), .m1_waitrequest(s_m1_waitrequest), .m1_readdata(s_m1_readdata),
    .m1_readdatavalid(s_m1_readdatavalid),
    .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable), .mem_chipselect(s_mem_chipselect),
    .mem_write(s_mem_write), .mem_writedata(s_mem_writedata), .mem_clken(s_mem_clken),
    .mem_readdata(s_mem_readdata), .err_flag(s_err_flag), .err_addr(s_err_addr), .err_clear(err_clear)
  );

  // Behavioural single-port RAM with registered q.
  logic [31:0] ram [0:5119];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  typedef struct packed { logic [31:0] data; logic [31:0] cyc; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   n_vec = 0, n_err = 0;
  int   cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) check("m0 unexpected readdatavalid", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("m0 readdata", m0_readdata, e0.data);
        check("m0 readdatavalid cycle", cyc_cnt, e0.cyc);
      end
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) check("m1 unexpected readdatavalid", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("m1 readdata", m1_readdata, e1.data);
        check("m1 readdatavalid cycle", cyc_cnt, e1.cyc);
      end
    end
  end

  task automatic drv0(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    s0_read = 1'b0;
    s1_read = 1'b0;
  endtask

  // Sample grants mid-cycle; queue the response a read accepted now must produce next cycle.
  task automatic step(input string tag, input logic eg0, input logic eg1,
                      input logic p0, input logic [31:0] d0, input logic p1, input logic [31:0] d1);
    @(negedge clk);
    check({tag, " m0_waitrequest"}, {31'd0, m0_waitrequest}, {31'd0, !eg0});
    check({tag, " m1_waitrequest"}, {31'd0, m1_waitrequest}, {31'd0, !eg1});
    if (p0) q0.push_back('{data: d0, cyc: cyc_cnt + 1});
    if (p1) q1.push_back('{data: d1, cyc: cyc_cnt + 1});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; err_clear = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("reset m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    check("reset m0_readdata", m0_readdata, 32'h0);
    check("reset mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset err_flag", {31'd0, err_flag}, 32'd0);
    check("reset err_addr", {19'd0, err_addr}, 32'd0);
    check("mem_clken", {31'd0, mem_clken}, 32'd1);
    adv(); reset = 1'b0;

    // write then read back through m0
    drv0(1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
    step("t1 write", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t1 mem_chipselect", {31'd0, mem_chipselect}, 32'd1);
    check("t1 mem_write", {31'd0, mem_write}, 32'd1);
    check("t1 mem_address", {19'd0, mem_address}, 32'h0010);
    adv();
    drv0(1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    step("t1 read", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
    check("t1 read mem_write", {31'd0, mem_write}, 32'd0);
    adv();

    // byte-lane merge
    drv0(1'b0, 1'b1, 13'h0011, 4'hF, 32'h11223344);   step("t5 w1", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0); adv();
    drv0(1'b0, 1'b1, 13'h0011, 4'b0010, 32'h0000AB00); step("t5 w2", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0); adv();
    drv0(1'b1, 1'b0, 13'h0011, 4'hF, 32'h0);          step("t5 rd", 1'b1, 1'b0, 1'b1, 32'h1122AB44, 1'b0, 0); adv();

    // read+write together is a write with no response
    drv0(1'b1, 1'b1, 13'h0012, 4'hF, 32'h00000055);   step("rw", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0); adv();
    drv0(1'b1, 1'b0, 13'h0012, 4'hF, 32'h0);          step("rw rd", 1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 0); adv();

    // out-of-range handling and error capture
    idle();
    drv1(1'b1, 1'b0, 13'h1400, 4'hF, 32'h0);
    step("t4 oor rd", 1'b0, 1'b1, 1'b0, 0, 1'b1, 32'h0);
    check("t4 oor chipselect", {31'd0, mem_chipselect}, 32'd0);
    adv(); idle();
    step("t4 idle", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t4 err_flag", {31'd0, err_flag}, 32'd1);
    check("t4 err_addr", {19'd0, err_addr}, 32'h1400);
    adv();
    drv0(1'b0, 1'b1, 13'h1FFF, 4'hF, 32'h1);
    step("t4 oor wr", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t4 oor wr mem_write", {31'd0, mem_write}, 32'd0);
    adv(); idle();
    step("t4 hold", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t4 first err_addr kept", {19'd0, err_addr}, 32'h1400);
    adv(); err_clear = 1'b1;
    step("t4 clear", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    adv(); err_clear = 1'b0;
    step("t4 cleared", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t4 err_flag cleared", {31'd0, err_flag}, 32'd0);
    check("t4 err_addr cleared", {19'd0, err_addr}, 32'h0);
    adv();
    drv0(1'b1, 1'b0, 13'h1401, 4'hF, 32'h0);
    step("t4 oor rd m0", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 0);
    adv(); idle(); err_clear = 1'b1;
    drv1(1'b0, 1'b1, 13'h1500, 4'hF, 32'h0);
    step("t4 clear+err", 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    adv(); idle(); err_clear = 1'b0;
    step("t4 err wins", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t4 err wins flag", {31'd0, err_flag}, 32'd1);
    check("t4 err wins addr", {19'd0, err_addr}, 32'h1500);
    adv();

    // round-robin: preload via m1, reset so last_grant=m1, then both read continuously
    for (int i = 0; i < 8; i++) begin
      drv1(1'b0, 1'b1, 13'(13'h20 + i), 4'hF, 32'hA0000000 + 32'(i));
      step("t2 preload", 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
      adv();
    end
    idle(); reset = 1'b1; adv(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv0(i < 7, 1'b0, 13'(13'h20 + (i + 1) / 2), 4'hF, 32'h0);
      drv1(1'b1, 1'b0, 13'(13'h24 + i / 2), 4'hF, 32'h0);
      step("t2 rr", (i % 2) == 0, (i % 2) == 1,
           (i % 2) == 0, 32'hA0000000 + 32'(i / 2),
           (i % 2) == 1, 32'hA0000004 + 32'(i / 2));
      adv();
    end
    idle(); step("t2 tail", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0); adv();

    // fixed priority with STARVE_LIMIT=3: m1 forced through on the 4th contested cycle
    reset = 1'b1; adv(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s0_read = 1'b1; s1_read = 1'b1;
      @(negedge clk);
      check("t3 fp m0_waitrequest", {31'd0, s_m0_waitrequest}, {31'd0, i == 3});
      check("t3 fp m1_waitrequest", {31'd0, s_m1_waitrequest}, {31'd0, i != 3});
      if (i == 4) begin
        check("t3 fp m1_readdatavalid", {31'd0, s_m1_readdatavalid}, 32'd1);
        check("t3 fp m1_readdata", s_m1_readdata, 32'hC0FFEE00);
      end
      if (i == 1) check("t3 fp m0_readdatavalid", {31'd0, s_m0_readdatavalid}, 32'd1);
      adv();
    end
    idle(); adv();

    // reset right after a read is accepted swallows the response
    drv0(1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    step("t6 rd", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    adv(); reset = 1'b1;
    step("t6 in reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t6 readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    check("t6 readdata", m0_readdata, 32'h0);
    check("t6 chipselect", {31'd0, mem_chipselect}, 32'd0);
    check("t6 err_flag", {31'd0, err_flag}, 32'd0);
    adv(); reset = 1'b0; idle();
    step("t6 after", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("t6 after readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    adv();

    repeat (2) adv();
    check("m0 responses outstanding", 32'(q0.size()), 32'd0);
    check("m1 responses outstanding", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
